// File: rtl/eq_arb_pkg.sv
// rtl/eq_arb_pkg.sv - shared types and constants for the equality compare arbiter
package eq_arb_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int CNT_WIDTH      = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RSP  = 2'd2
  } state_e;

endpackage

// File: rtl/eq_compare_unit.sv
// rtl/eq_compare_unit.sv - combinational unsigned equality comparator with select
module eq_compare_unit
  import eq_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  output logic                  eq_out,
  output logic                  ne_out,
  output logic [DATA_WIDTH-1:0] sel_out
);

  logic w_eq;

  assign w_eq    = (a_in == b_in);
  assign eq_out  = w_eq;
  assign ne_out  = ~w_eq;
  assign sel_out = w_eq ? a_in : b_in;

endmodule

// File: rtl/equality_compare_arbiter.sv
// rtl/equality_compare_arbiter.sv - two-requester round-robin equality compare engine; EQ_ARB_STATS_EN adds match/mismatch counters
module equality_compare_arbiter
  import eq_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req0_valid_in,
  input  logic [DATA_WIDTH-1:0] req0_a_in,
  input  logic [DATA_WIDTH-1:0] req0_b_in,
  output logic                  req0_ready_out,
  input  logic                  req1_valid_in,
  input  logic [DATA_WIDTH-1:0] req1_a_in,
  input  logic [DATA_WIDTH-1:0] req1_b_in,
  output logic                  req1_ready_out,
  input  logic                  rsp_ready_in,
  output logic                  rsp_valid_out,
  output logic                  rsp_id_out,
  output logic                  rsp_eq_out,
  output logic                  rsp_ne_out,
  output logic [DATA_WIDTH-1:0] rsp_sel_out
`ifdef EQ_ARB_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  match_cnt_out,
  output logic [CNT_WIDTH-1:0]  mismatch_cnt_out
`endif
);

  state_e                r_state;
  state_e                w_state_nxt;
  logic                  r_last_grant;
  logic                  r_id;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic                  r_eq;
  logic                  r_ne;
  logic [DATA_WIDTH-1:0] r_sel;

  logic                  w_any_valid;
  logic                  w_grant_id;
  logic                  w_xfer;
  logic                  w_cmp_eq;
  logic                  w_cmp_ne;
  logic [DATA_WIDTH-1:0] w_cmp_sel;

  // On contention the requester that did not win last time goes next.
  assign w_any_valid = req0_valid_in | req1_valid_in;
  assign w_grant_id  = (req0_valid_in & req1_valid_in) ? ~r_last_grant : ~req0_valid_in;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    req0_ready_out = 1'b0;
    req1_ready_out = 1'b0;
    w_xfer         = 1'b0;
    case (r_state)
      IDLE: begin
        req0_ready_out = req0_valid_in & ~w_grant_id;
        req1_ready_out = req1_valid_in & w_grant_id;
        w_xfer         = w_any_valid;
        if (w_any_valid) begin
          w_state_nxt = CMP;
        end
      end
      CMP: begin
        w_state_nxt = RSP;
      end
      RSP: begin
        if (rsp_ready_in) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  eq_compare_unit #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_cmp (
    .a_in   (r_a),
    .b_in   (r_b),
    .eq_out (w_cmp_eq),
    .ne_out (w_cmp_ne),
    .sel_out(w_cmp_sel)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_eq         <= 1'b0;
      r_ne         <= 1'b0;
      r_sel        <= '0;
    end else begin
      if (w_xfer) begin
        r_a          <= w_grant_id ? req1_a_in : req0_a_in;
        r_b          <= w_grant_id ? req1_b_in : req0_b_in;
        r_id         <= w_grant_id;
        r_last_grant <= w_grant_id;
      end
      if (r_state == CMP) begin
        r_eq  <= w_cmp_eq;
        r_ne  <= w_cmp_ne;
        r_sel <= w_cmp_sel;
      end
    end
  end

  assign rsp_valid_out = (r_state == RSP);
  assign rsp_id_out    = r_id;
  assign rsp_eq_out    = r_eq;
  assign rsp_ne_out    = r_ne;
  assign rsp_sel_out   = r_sel;

`ifdef EQ_ARB_STATS_EN
  logic [CNT_WIDTH-1:0] r_match_cnt;
  logic [CNT_WIDTH-1:0] r_mismatch_cnt;

  // Counted on the CMP->RSP edge; both counters saturate rather than wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_match_cnt    <= '0;
      r_mismatch_cnt <= '0;
    end else if (r_state == CMP) begin
      if (w_cmp_eq && (r_match_cnt != {CNT_WIDTH{1'b1}})) begin
        r_match_cnt <= r_match_cnt + 1'b1;
      end
      if (!w_cmp_eq && (r_mismatch_cnt != {CNT_WIDTH{1'b1}})) begin
        r_mismatch_cnt <= r_mismatch_cnt + 1'b1;
      end
    end
  end

  assign match_cnt_out    = r_match_cnt;
  assign mismatch_cnt_out = r_mismatch_cnt;
`endif

endmodule

// File: tb/tb_equality_compare_arbiter.sv
// tb/tb_equality_compare_arbiter.sv - directed and randomized self-checking bench for equality_compare_arbiter
module tb_equality_compare_arbiter;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req0_valid_in, req1_valid_in;
  logic [DW-1:0] req0_a_in, req0_b_in, req1_a_in, req1_b_in;
  logic          req0_ready_out, req1_ready_out;
  logic          rsp_ready_in;
  logic          rsp_valid_out, rsp_id_out, rsp_eq_out, rsp_ne_out;
  logic [DW-1:0] rsp_sel_out;
`ifdef EQ_ARB_STATS_EN
  logic [15:0]   match_cnt_out, mismatch_cnt_out;
`endif

  int n_vec = 0;
  int n_err = 0;
  int n_match = 0;
  int n_mismatch = 0;
  logic m_last_grant;

  always #5 clk = ~clk;

  equality_compare_arbiter #(.DATA_WIDTH(DW)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .req0_valid_in   (req0_valid_in),
    .req0_a_in       (req0_a_in),
    .req0_b_in       (req0_b_in),
    .req0_ready_out  (req0_ready_out),
    .req1_valid_in   (req1_valid_in),
    .req1_a_in       (req1_a_in),
    .req1_b_in       (req1_b_in),
    .req1_ready_out  (req1_ready_out),
    .rsp_ready_in    (rsp_ready_in),
    .rsp_valid_out   (rsp_valid_out),
    .rsp_id_out      (rsp_id_out),
    .rsp_eq_out      (rsp_eq_out),
    .rsp_ne_out      (rsp_ne_out),
    .rsp_sel_out     (rsp_sel_out)
`ifdef EQ_ARB_STATS_EN
    ,
    .match_cnt_out   (match_cnt_out),
    .mismatch_cnt_out(mismatch_cnt_out)
`endif
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_rsp(input logic id, input logic eq, input logic [DW-1:0] sel);
    chk1("rsp_valid", rsp_valid_out, 1'b1);
    chk1("rsp_id", rsp_id_out, id);
    chk1("rsp_eq", rsp_eq_out, eq);
    chk1("rsp_ne", rsp_ne_out, ~eq);
    chkd("rsp_sel", rsp_sel_out, sel);
    chk1("rsp_r0_low", req0_ready_out, 1'b0);
    chk1("rsp_r1_low", req1_ready_out, 1'b0);
  endtask

  // Called at a falling edge with the DUT idle; stall = extra RSP cycles with rsp_ready_in low.
  task automatic txn(input logic v0, input logic v1,
                     input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                     input logic [DW-1:0] a1, input logic [DW-1:0] b1,
                     input int stall);
    logic          g;
    logic [DW-1:0] ea, eb, esel;
    logic          eeq;
    req0_valid_in = v0;
    req1_valid_in = v1;
    req0_a_in     = a0;
    req0_b_in     = b0;
    req1_a_in     = a1;
    req1_b_in     = b1;
    rsp_ready_in  = (stall == 0);
    #1;
    chk1("ready_onehot", req0_ready_out & req1_ready_out, 1'b0);
    if (!(v0 | v1)) begin
      chk1("noreq_r0", req0_ready_out, 1'b0);
      chk1("noreq_r1", req1_ready_out, 1'b0);
      step();
      chk1("noreq_rv", rsp_valid_out, 1'b0);
      return;
    end
    g = (v0 && v1) ? ~m_last_grant : (v1 && !v0);
    m_last_grant = g;
    ea   = g ? a1 : a0;
    eb   = g ? b1 : b0;
    eeq  = (ea == eb);
    esel = eeq ? ea : eb;
    if (eeq) n_match++;
    else     n_mismatch++;
    chk1("grant_r0", req0_ready_out, ~g);
    chk1("grant_r1", req1_ready_out, g);
    step();
    chk1("cmp_r0_low", req0_ready_out, 1'b0);
    chk1("cmp_r1_low", req1_ready_out, 1'b0);
    chk1("cmp_rv_low", rsp_valid_out, 1'b0);
    step();
    check_rsp(g, eeq, esel);
    for (int i = 0; i < stall; i++) begin
      step();
      check_rsp(g, eeq, esel);
    end
    rsp_ready_in = 1'b1;
    step();
    chk1("back_to_idle", rsp_valid_out, 1'b0);
  endtask

  initial begin
    logic          v0, v1;
    logic [DW-1:0] a0, b0, a1, b1;
    reset_n       = 1'b0;
    req0_valid_in = 1'b0;
    req1_valid_in = 1'b0;
    req0_a_in     = '0;
    req0_b_in     = '0;
    req1_a_in     = '0;
    req1_b_in     = '0;
    rsp_ready_in  = 1'b1;
    m_last_grant  = 1'b1;
    repeat (2) @(negedge clk);
    chk1("rst_valid", rsp_valid_out, 1'b0);
    chk1("rst_id", rsp_id_out, 1'b0);
    chk1("rst_eq", rsp_eq_out, 1'b0);
    chk1("rst_ne", rsp_ne_out, 1'b0);
    chkd("rst_sel", rsp_sel_out, 8'h00);
    reset_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      txn(1'b1, 1'b1, 8'(i), 8'(i), 8'(i + 16), 8'(i + 3), 0);
      chk1("contention_alt", m_last_grant, i[0]);
    end

    txn(1'b1, 1'b0, 8'h5A, 8'h5A, 8'h00, 8'h00, 0);
    txn(1'b0, 1'b1, 8'h00, 8'h00, 8'h12, 8'h34, 0);
    txn(1'b1, 1'b0, 8'hFF, 8'h7F, 8'h00, 8'h00, 5);
    txn(1'b0, 1'b1, 8'h00, 8'h00, 8'h80, 8'h80, 0);

    req0_valid_in = 1'b1;
    req1_valid_in = 1'b0;
    req0_a_in     = 8'hC3;
    req0_b_in     = 8'hC3;
    #1;
    chk1("midrst_grant", req0_ready_out, 1'b1);
    step();
    reset_n       = 1'b0;
    req0_valid_in = 1'b0;
    #1;
    chk1("midrst_rv_now", rsp_valid_out, 1'b0);
    step();
    reset_n      = 1'b1;
    m_last_grant = 1'b1;
    n_match      = 0;
    n_mismatch   = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk1("midrst_no_rsp", rsp_valid_out, 1'b0);
    end

    for (int i = 0; i < 150; i++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      a0 = 8'($urandom);
      a1 = 8'($urandom);
      b0 = ($urandom_range(0, 1) == 1) ? a0 : 8'($urandom);
      b1 = ($urandom_range(0, 1) == 1) ? a1 : 8'($urandom);
      txn(v0, v1, a0, b0, a1, b1, int'($urandom_range(0, 3)));
    end

`ifdef EQ_ARB_STATS_EN
    n_vec++;
    assert (match_cnt_out === 16'(n_match)) else begin
      n_err++;
      $error("FAIL match_cnt observed=%0d expected=%0d", match_cnt_out, n_match);
    end
    n_vec++;
    assert (mismatch_cnt_out === 16'(n_mismatch)) else begin
      n_err++;
      $error("FAIL mismatch_cnt observed=%0d expected=%0d", mismatch_cnt_out, n_mismatch);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
